// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e : FSM state encodings (also the value driven on state_o)
//   - PC_SRC_*      : next-PC select encodings for pc_src_i
//   - HALT_WORD_DEF : default instruction encoding that stops fetching
//   - NOP_WORD_DEF  : default bubble placed on instruction_o by a flush
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11   // reachable only when IF_STEP_EN is defined
  } fetch_state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_inst_mem.sv
// ----------------------------------------------------------------------------
// if_inst_mem
// Instruction memory, NB_DATA x 2^WORD_AW words. Contents have no reset.
// Ports:
//   i_clk       clock
//   i_wr_en     write strobe, word i_wr_data stored at i_wr_addr on the edge
//   i_wr_addr   word write address
//   i_wr_data   write data
//   i_rd_en     read strobe, o_rd_data reloaded from i_rd_addr on the edge
//   i_rd_addr   word read address
//   o_rd_data   registered read data, held while i_rd_en is low
// A read and a write to the same word on the same edge return the new data,
// so a word loaded on the start edge is what gets fetched first.
// ----------------------------------------------------------------------------
module if_inst_mem #(
  parameter int NB_DATA = 32,
  parameter int WORD_AW = 8
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [WORD_AW-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [WORD_AW-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [NB_DATA-1:0] r_mem [0:DEPTH-1];
  logic [NB_DATA-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
        r_rd_data <= i_wr_data;
      end else begin
        r_rd_data <= r_mem[i_rd_addr];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage with a debug-loadable instruction memory.
// Optional feature macro: IF_STEP_EN (adds step_i and the STEP state).
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   en_write_i, wr_addr_i,
//   instruction_i             memory load (accepted in IDLE and HALT only)
//   start_i                   leave IDLE/HALT, PC restarts at 0
//   step_i                    (IF_STEP_EN) with start_i selects STEP; in STEP
//                             each pulse performs one fetch
//   enable_i                  advance; 0 stalls PC and all outputs
//   flush_i                   replace the fetched word with NOP_WORD
//   pc_src_i, addr_branch_i,
//   addr_jump_i, addr_register_i  next-PC select and targets
//   instruction_o, pc_o       fetched word and its PC+4
//   valid_o, halt_o, state_o  status; state_o is the FSM state
// valid_o semantics: valid_o=1 marks the single cycle-registered word on
// instruction_o as a real, unflushed, non-halt fetch; there is no downstream
// ready, the consumer must accept it or drop enable_i to stall.
// ----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                 NB_DATA    = 32,
  parameter int                 ADDR_WIDTH = 10,
  parameter logic [NB_DATA-1:0] HALT_WORD  = HALT_WORD_DEF,
  parameter logic [NB_DATA-1:0] NOP_WORD   = NOP_WORD_DEF
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  en_write_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0]    instruction_i,
  input  logic                  start_i,
`ifdef IF_STEP_EN
  input  logic                  step_i,
`endif
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [1:0]            pc_src_i,
  input  logic [ADDR_WIDTH-1:0] addr_branch_i,
  input  logic [ADDR_WIDTH-1:0] addr_jump_i,
  input  logic [ADDR_WIDTH-1:0] addr_register_i,
  output logic [NB_DATA-1:0]    instruction_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  valid_o,
  output logic                  halt_o,
  output logic [1:0]            state_o
);

  localparam int WORD_AW = ADDR_WIDTH - 2;

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [NB_DATA-1:0]    r_instr;
  logic [ADDR_WIDTH-1:0] r_pc_o;
  logic                  r_valid;
  logic                  r_halt;

  logic                  w_step;
  logic                  w_idle_like;
  logic                  w_start;
  logic                  w_fetch;
  logic                  w_halt_hit;
  logic                  w_mem_we;
  logic                  w_pc_load;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_pc_target;
  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [NB_DATA-1:0]    w_rd_data;
  logic [1:0]            w_unused_wr_lsb;

`ifdef IF_STEP_EN
  assign w_step = step_i;
`else
  assign w_step = 1'b0;
`endif

  // Byte-offset bits of the load address do not select anything.
  assign w_unused_wr_lsb = wr_addr_i[1:0];

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign w_start     = w_idle_like && start_i;
  assign w_mem_we    = en_write_i && w_idle_like && !reset_i;

  assign w_fetch    = enable_i &&
                      ((r_state == ST_RUN) || ((r_state == ST_STEP) && w_step));
  // A flushed halt word is just a squashed instruction, not a stop.
  assign w_halt_hit = w_fetch && !flush_i && (w_rd_data == HALT_WORD);

  // Natural ADDR_WIDTH overflow gives the wrap from the last word to 0.
  assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

  always_comb begin
    w_pc_target = w_pc_plus4;
    case (pc_src_i)
      PC_SRC_SEQ:    w_pc_target = w_pc_plus4;
      PC_SRC_BRANCH: w_pc_target = addr_branch_i   & ~ADDR_WIDTH'(3);
      PC_SRC_JUMP:   w_pc_target = addr_jump_i     & ~ADDR_WIDTH'(3);
      PC_SRC_REG:    w_pc_target = addr_register_i & ~ADDR_WIDTH'(3);
      default:       w_pc_target = w_pc_plus4;
    endcase
  end

  // The memory read port is addressed with the PC value being loaded, so the
  // word at the current PC is always sitting in w_rd_data when a fetch edge
  // arrives. Reset and start both reload it from word 0.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_d    = r_pc;
    if (reset_i || w_start) begin
      w_pc_load = 1'b1;
      w_pc_d    = '0;
    end else if (w_fetch && !w_halt_hit) begin
      w_pc_load = 1'b1;
      w_pc_d    = w_pc_target;
    end
  end

  if_inst_mem #(
    .NB_DATA (NB_DATA),
    .WORD_AW (WORD_AW)
  ) u_inst_mem (
    .i_clk     (clock_i),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (wr_addr_i[ADDR_WIDTH-1:2]),
    .i_wr_data (instruction_i),
    .i_rd_en   (w_pc_load),
    .i_rd_addr (w_pc_d[ADDR_WIDTH-1:2]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_instr <= NOP_WORD;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_pc_d;
      end
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start_i) begin
            r_state <= w_step ? ST_STEP : ST_RUN;
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
          end
        end
        ST_RUN, ST_STEP: begin
          if (w_fetch) begin
            r_pc_o <= w_pc_plus4;
            if (flush_i) begin
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end else if (w_halt_hit) begin
              r_instr <= HALT_WORD;
              r_valid <= 1'b0;
              r_halt  <= 1'b1;
              r_state <= ST_HALT;
            end else begin
              r_instr <= w_rd_data;
              r_valid <= 1'b1;
            end
          end else if (r_state == ST_STEP) begin
            // Between step pulses nothing new was fetched.
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instruction_o = r_instr;
  assign pc_o          = r_pc_o;
  assign valid_o       = r_valid;
  assign halt_o        = r_halt;
  assign state_o       = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int NB_DATA    = 32;
  localparam int ADDR_WIDTH = 10;

  // clock / reset
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  logic                  en_write_i      = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr_i       = '0;
  logic [NB_DATA-1:0]    instruction_i   = '0;
  logic                  start_i         = 1'b0;
  logic                  step_i          = 1'b0;
  logic                  enable_i        = 1'b1;
  logic                  flush_i         = 1'b0;
  logic [1:0]            pc_src_i        = 2'b00;
  logic [ADDR_WIDTH-1:0] addr_branch_i   = '0;
  logic [ADDR_WIDTH-1:0] addr_jump_i     = '0;
  logic [ADDR_WIDTH-1:0] addr_register_i = '0;
  logic [NB_DATA-1:0]    instruction_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  valid_o;
  logic                  halt_o;
  logic [1:0]            state_o;

  if_fetch_unit #(
    .NB_DATA    (NB_DATA),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .en_write_i      (en_write_i),
    .wr_addr_i       (wr_addr_i),
    .instruction_i   (instruction_i),
    .start_i         (start_i),
`ifdef IF_STEP_EN
    .step_i          (step_i),
`endif
    .enable_i        (enable_i),
    .flush_i         (flush_i),
    .pc_src_i        (pc_src_i),
    .addr_branch_i   (addr_branch_i),
    .addr_jump_i     (addr_jump_i),
    .addr_register_i (addr_register_i),
    .instruction_o   (instruction_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .halt_o          (halt_o),
    .state_o         (state_o)
  );

  int total = 0;
  int bad   = 0;
  logic [NB_DATA-1:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_WIDTH-1:0] a, input logic [NB_DATA-1:0] d);
    en_write_i    = 1'b1;
    wr_addr_i     = a;
    instruction_i = d;
    tick();
    en_write_i    = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    total++; if (state_o !== 2'b00) begin bad++; $display("FAIL reset_state got=%h exp=0", state_o); end
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruction_o); end
    total++; if (pc_o !== 10'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt_o); end
  endtask

  task automatic test_load_run_halt();
    logic [31:0] e_instr [4] = '{32'h2001_0005, 32'h2002_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [9:0]  e_pc    [4] = '{10'h004, 10'h008, 10'h00C, 10'h00C};
    logic        e_valid [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        e_halt  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  e_state [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    load_word(10'h000, 32'h2001_0005);
    load_word(10'h004, 32'h2002_0007);
    load_word(10'h008, 32'hFFFF_FFFF);
    load_word(10'h00C, 32'h3333_3333);
    load_word(10'h010, 32'hFFFF_FFFF);
    load_word(10'h040, 32'h1616_1616);
    load_word(10'h0A0, 32'h4040_4040);
    load_word(10'h320, 32'hC8C8_C8C8);
    load_word(10'h3FC, 32'h0FF0_0FF0);
    total++; if (state_o !== 2'b00) begin bad++; $display("FAIL load_idle got=%h exp=0", state_o); end
    do_start();
    total++; if (state_o !== 2'b01) begin bad++; $display("FAIL start_run got=%h exp=1", state_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (instruction_o !== e_instr[i]) begin bad++; $display("FAIL run_instr[%0d] got=%h exp=%h", i, instruction_o, e_instr[i]); end
      total++; if (pc_o !== e_pc[i]) begin bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, pc_o, e_pc[i]); end
      total++; if (valid_o !== e_valid[i]) begin bad++; $display("FAIL run_valid[%0d] got=%b exp=%b", i, valid_o, e_valid[i]); end
      total++; if (halt_o !== e_halt[i]) begin bad++; $display("FAIL run_halt[%0d] got=%b exp=%b", i, halt_o, e_halt[i]); end
      total++; if (state_o !== e_state[i]) begin bad++; $display("FAIL run_state[%0d] got=%h exp=%h", i, state_o, e_state[i]); end
    end
  endtask

  task automatic test_pc_select();
    logic [1:0] src  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic       strt [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0] e_pc [4] = '{10'h004, 10'h044, 10'h0A4, 10'h324};
    logic [NB_DATA-1:0] exp_w;
    exp_q = '{32'h2001_0005, 32'h1616_1616, 32'h4040_4040, 32'hC8C8_C8C8};
    addr_branch_i   = 10'h040;
    addr_jump_i     = 10'h0A3;
    addr_register_i = 10'h320;
    do_start();
    for (int i = 0; i < 4; i++) begin
      pc_src_i = src[i];
      start_i  = strt[i];
      tick();
      exp_w = exp_q.pop_front();
      total++; if (instruction_o !== exp_w) begin bad++; $display("FAIL sel_instr[%0d] got=%h exp=%h", i, instruction_o, exp_w); end
      total++; if (pc_o !== e_pc[i]) begin bad++; $display("FAIL sel_pc[%0d] got=%h exp=%h", i, pc_o, e_pc[i]); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL sel_valid[%0d] got=%b exp=1", i, valid_o); end
    end
    start_i  = 1'b0;
    pc_src_i = 2'b00;
  endtask

  task automatic test_stall_flush_wrap();
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush_i = (i == 1);
      tick();
      total++; if (instruction_o !== 32'hC8C8_C8C8) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=c8c8c8c8", i, instruction_o); end
      total++; if (pc_o !== 10'h324) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=324", i, pc_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid_o); end
    end
    enable_i        = 1'b1;
    flush_i         = 1'b1;
    pc_src_i        = 2'b11;
    addr_register_i = 10'h3FC;
    tick();
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL flush_instr got=%h exp=0", instruction_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    flush_i  = 1'b0;
    pc_src_i = 2'b00;
    tick();
    total++; if (instruction_o !== 32'h0FF0_0FF0) begin bad++; $display("FAIL wrap_instr got=%h exp=0ff00ff0", instruction_o); end
    total++; if (pc_o !== 10'h000) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc_o); end
    tick();
    total++; if (instruction_o !== 32'h2001_0005) begin bad++; $display("FAIL wrap_next got=%h exp=20010005", instruction_o); end
    total++; if (pc_o !== 10'h004) begin bad++; $display("FAIL wrap_next_pc got=%h exp=4", pc_o); end
  endtask

  task automatic test_reset_mid_run();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    total++; if (state_o !== 2'b00) begin bad++; $display("FAIL mid_reset_state got=%h exp=0", state_o); end
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL mid_reset_instr got=%h exp=0", instruction_o); end
    total++; if (pc_o !== 10'h0) begin bad++; $display("FAIL mid_reset_pc got=%h exp=0", pc_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", valid_o); end
    do_start();
    pc_src_i      = 2'b01;
    addr_branch_i = 10'h004;
    tick();
    pc_src_i = 2'b00;
    tick();
    total++; if (instruction_o !== 32'h2002_0007) begin bad++; $display("FAIL mem_kept got=%h exp=20020007", instruction_o); end
    total++; if (pc_o !== 10'h008) begin bad++; $display("FAIL mem_kept_pc got=%h exp=8", pc_o); end
    tick();
    total++; if (halt_o !== 1'b1) begin bad++; $display("FAIL rehalt got=%b exp=1", halt_o); end
  endtask

  task automatic test_write_rules();
    // start and write together from HALT; low address bits ignored
    start_i       = 1'b1;
    en_write_i    = 1'b1;
    wr_addr_i     = 10'h001;
    instruction_i = 32'h5A5A_0001;
    tick();
    start_i       = 1'b0;
    wr_addr_i     = 10'h004;
    instruction_i = 32'hDEAD_BEEF;
    total++; if (state_o !== 2'b01) begin bad++; $display("FAIL wr_start_state got=%h exp=1", state_o); end
    tick();
    en_write_i = 1'b0;
    total++; if (instruction_o !== 32'h5A5A_0001) begin bad++; $display("FAIL wr_same_edge got=%h exp=5a5a0001", instruction_o); end
    tick();
    total++; if (instruction_o !== 32'h2002_0007) begin bad++; $display("FAIL wr_run_ignored got=%h exp=20020007", instruction_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL flush_halt_instr got=%h exp=0", instruction_o); end
    total++; if (state_o !== 2'b01) begin bad++; $display("FAIL flush_halt_state got=%h exp=1", state_o); end
    total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL flush_halt_flag got=%b exp=0", halt_o); end
    tick();
    total++; if (instruction_o !== 32'h3333_3333) begin bad++; $display("FAIL after_flush got=%h exp=33333333", instruction_o); end
    total++; if (pc_o !== 10'h010) begin bad++; $display("FAIL after_flush_pc got=%h exp=10", pc_o); end
    tick();
    total++; if (state_o !== 2'b10) begin bad++; $display("FAIL halt2_state got=%h exp=2", state_o); end
    total++; if (pc_o !== 10'h014) begin bad++; $display("FAIL halt2_pc got=%h exp=14", pc_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL halt2_valid got=%b exp=0", valid_o); end
  endtask

`ifdef IF_STEP_EN
  task automatic test_step();
    logic pulses [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   n_valid;
    n_valid = 0;
    start_i = 1'b1;
    step_i  = 1'b1;
    tick();
    start_i = 1'b0;
    step_i  = 1'b0;
    total++; if (state_o !== 2'b11) begin bad++; $display("FAIL step_enter got=%h exp=3", state_o); end
    for (int i = 0; i < 6; i++) begin
      step_i = pulses[i];
      tick();
      if (valid_o === 1'b1) n_valid++;
    end
    step_i = 1'b0;
    total++; if (n_valid !== 2) begin bad++; $display("FAIL step_count got=%0d exp=2", n_valid); end
    total++; if (pc_o !== 10'h008) begin bad++; $display("FAIL step_pc got=%h exp=8", pc_o); end
    total++; if (instruction_o !== 32'h2002_0007) begin bad++; $display("FAIL step_instr got=%h exp=20020007", instruction_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_run_halt();
    test_pc_select();
    test_stall_flush_wrap();
    test_reset_mid_run();
    test_write_rules();
`ifdef IF_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
